// File: rtl/conv_pass_sequencer.sv
// Controls one convolution pass: latches the pass configuration, then sequences
// PRIME -> tap bursts with idle gaps -> skew drain -> done for the west-side weight scheduler.
module conv_pass_sequencer #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int PIX_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_sync_i,
  input  logic             start_i,
  input  logic [3:0]       cfg_kernel_r_i,
  input  logic [PIX_W-1:0] cfg_out_pixels_i,
  input  logic [7:0]       cfg_gap_i,
  input  logic             stall_i,
  output logic             sched_enable_o,
  output logic             sched_sync_o,
  output logic [7:0]       tap_idx_o,
  output logic [PIX_W-1:0] burst_idx_o,
  output logic [COLS-1:0]  col_mask_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int DRAIN_LEN = ROWS + COLS - 2;
  localparam logic [15:0]    DRAIN_LAST = 16'(DRAIN_LEN - 1);
  localparam logic [PIX_W:0] COLS_W     = (PIX_W+1)'(COLS);
  localparam logic [PIX_W:0] COLS_M1    = (PIX_W+1)'(COLS - 1);
  localparam logic [PIX_W:0] ONE_W      = (PIX_W+1)'(1);

  logic [2:0]       r_state;
  logic [7:0]       r_taps;
  logic [7:0]       r_gap;
  logic [PIX_W-1:0] r_last_idx;
  logic [COLS-1:0]  r_last_mask;
  logic [7:0]       r_gap_cnt;
  logic [15:0]      r_drain_cnt;

  logic             r_enable;
  logic             r_sync;
  logic [7:0]       r_tap;
  logic [PIX_W-1:0] r_burst_idx;
  logic [COLS-1:0]  r_col_mask;
  logic             r_busy;
  logic             r_done;
  logic             r_cfg_err;

  // Burst count and the partial-column remainder of the final burst (1..COLS).
  logic [PIX_W:0]   w_pix_ext;
  logic [PIX_W:0]   w_nb_ext;
  logic [PIX_W:0]   w_last_idx_ext;
  logic [PIX_W:0]   w_rem;
  logic [COLS-1:0]  w_last_mask;
  logic [7:0]       w_taps;
  logic             w_cfg_bad;
  logic             w_tap_last;
  logic             w_is_last;
  logic             w_next_is_last;
  logic             w_gap_done;
  logic [PIX_W-1:0] w_burst_inc;

  assign w_pix_ext      = {1'b0, cfg_out_pixels_i};
  assign w_nb_ext       = (w_pix_ext + COLS_M1) / COLS_W;
  assign w_last_idx_ext = w_nb_ext - ONE_W;
  assign w_rem          = w_pix_ext - w_last_idx_ext * COLS_W;
  assign w_taps         = {4'd0, cfg_kernel_r_i} * {4'd0, cfg_kernel_r_i};
  assign w_cfg_bad      = (cfg_kernel_r_i == 4'd0) || (cfg_out_pixels_i == '0);

  for (genvar gi = 0; gi < COLS; gi++) begin : g_mask
    assign w_last_mask[gi] = (w_rem > (PIX_W+1)'(gi));
  end

  assign w_tap_last     = (r_tap == r_taps - 8'd1);
  assign w_burst_inc    = r_burst_idx + PIX_W'(1);
  assign w_is_last      = (r_burst_idx == r_last_idx);
  assign w_next_is_last = (w_burst_inc == r_last_idx);
  // gap==0 counts as already expired, which gives the stall-only hold behaviour.
  assign w_gap_done     = ({1'b0, r_gap_cnt} + 9'd1) >= {1'b0, r_gap};

  always_ff @(posedge clk_i) begin
    if (rst_sync_i) begin
      r_state     <= S_IDLE;
      r_taps      <= '0;
      r_gap       <= '0;
      r_last_idx  <= '0;
      r_last_mask <= '0;
      r_gap_cnt   <= '0;
      r_drain_cnt <= '0;
      r_enable    <= 1'b0;
      r_sync      <= 1'b0;
      r_tap       <= '0;
      r_burst_idx <= '0;
      r_col_mask  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (w_cfg_bad) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_taps      <= w_taps;
              r_gap       <= cfg_gap_i;
              r_last_idx  <= w_last_idx_ext[PIX_W-1:0];
              r_last_mask <= w_last_mask;
              r_burst_idx <= '0;
              r_state     <= S_PRIME;
              r_enable    <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end
        S_PRIME: begin
          if (!stall_i) begin
            r_state    <= S_BURST;
            r_sync     <= 1'b1;
            r_tap      <= '0;
            r_col_mask <= (r_last_idx == '0) ? r_last_mask : '1;
          end
        end
        S_BURST: begin
          if (w_tap_last) begin
            r_tap      <= '0;
            r_sync     <= 1'b0;
            r_col_mask <= '0;
            if (w_is_last) begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= '0;
            end else begin
              r_burst_idx <= w_burst_inc;
              r_gap_cnt   <= '0;
              if (r_gap == 8'd0 && !stall_i) begin
                r_sync     <= 1'b1;
                r_col_mask <= w_next_is_last ? r_last_mask : '1;
              end else begin
                r_state <= S_GAP;
              end
            end
          end else begin
            r_tap <= r_tap + 8'd1;
          end
        end
        S_GAP: begin
          if (w_gap_done && !stall_i) begin
            r_state    <= S_BURST;
            r_sync     <= 1'b1;
            r_tap      <= '0;
            r_col_mask <= w_is_last ? r_last_mask : '1;
          end else if (!w_gap_done) begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state  <= S_DONE;
            r_enable <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_enable <= 1'b0;
          r_sync   <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign sched_enable_o = r_enable;
  assign sched_sync_o   = r_sync;
  assign tap_idx_o      = r_tap;
  assign burst_idx_o    = r_burst_idx;
  assign col_mask_o     = r_col_mask;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign cfg_err_o      = r_cfg_err;

endmodule
